// File: rtl/block_sync_deser_pkg.sv
// Shared types and constants for the 66-bit block synchroniser.
// Holds the lock state encoding, the valid sync-header codes and the default sizes.
package block_sync_deser_pkg;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } lock_state_e;

   localparam logic [1:0] SH_DATA = 2'b01;
   localparam logic [1:0] SH_CTRL = 2'b10;

   localparam int BLK_W_DEF     = 66;
   localparam int LOCK_CNT_DEF  = 64;
   localparam int INVLD_MAX_DEF = 16;
   localparam int DATA_W        = 64;
   localparam int HDR_W         = 2;

   function automatic logic hdr_valid(input logic [HDR_W-1:0] hdr);
      return (hdr == SH_DATA) || (hdr == SH_CTRL);
   endfunction

endpackage

// File: rtl/block_sync_deser_if.sv
// Serial-in / aligned-block-out bus of the block synchroniser.
// The statistics counters exist only when BLOCK_SYNC_STATS_EN is defined.
interface block_sync_deser_if;
   import block_sync_deser_pkg::*;

   logic              serial_data_in;
   logic [DATA_W-1:0] block_data_out;
   logic [HDR_W-1:0]  block_hdr_out;
   logic              block_valid;
   logic              block_lock;
`ifdef BLOCK_SYNC_STATS_EN
   logic [15:0]       hdr_err_cnt;
   logic [15:0]       slip_cnt;
`endif

   modport master (
      input  serial_data_in,
      output block_data_out,
      output block_hdr_out,
      output block_valid,
      output block_lock
`ifdef BLOCK_SYNC_STATS_EN
      ,
      output hdr_err_cnt,
      output slip_cnt
`endif
   );

   modport slave (
      output serial_data_in,
      input  block_data_out,
      input  block_hdr_out,
      input  block_valid,
      input  block_lock
`ifdef BLOCK_SYNC_STATS_EN
      ,
      input  hdr_err_cnt,
      input  slip_cnt
`endif
   );

endinterface

// File: rtl/block_sync_deser_lock_fsm.sv
// Header-based lock state machine: counts good/bad sync headers per boundary,
// requests one-bit slips while hunting and flags which blocks may be delivered.
module block_lock_fsm
   import block_sync_deser_pkg::*;
#(
   parameter int LOCK_CNT  = LOCK_CNT_DEF,
   parameter int INVLD_MAX = INVLD_MAX_DEF
)(
   input  logic clk,
   input  logic rst_n,
   input  logic boundary,
   input  logic hdr_ok,
   output logic slip,
   output logic block_lock,
   output logic blk_ok
);

   localparam int SH_W = $clog2(LOCK_CNT + 1);
   localparam int IV_W = $clog2(INVLD_MAX + 1);

   lock_state_e     state_r;
   logic [SH_W-1:0] sh_cnt_r;
   logic [IV_W-1:0] sh_invld_r;
   logic [SH_W-1:0] sh_inc_s;
   logic [IV_W-1:0] iv_inc_s;
   logic            slip_r;
   logic            lock_r;

   assign sh_inc_s = sh_cnt_r + SH_W'(1);

   // next invalid count and whether the current block survives as a delivered block
   always_comb begin
      iv_inc_s = sh_invld_r;
      if (!hdr_ok) begin
         iv_inc_s = sh_invld_r + IV_W'(1);
      end else begin
         iv_inc_s = sh_invld_r;
      end
      blk_ok = (state_r == LOCKED) && (iv_inc_s != IV_W'(INVLD_MAX));
   end

   // lock state, window counters and the one-cycle slip pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= HUNT;
         sh_cnt_r   <= SH_W'(0);
         sh_invld_r <= IV_W'(0);
         slip_r     <= 1'b0;
         lock_r     <= 1'b0;
      end else begin
         slip_r <= 1'b0;
         if (boundary) begin
            case (state_r)
               HUNT: begin
                  if (hdr_ok) begin
                     if (sh_inc_s == SH_W'(LOCK_CNT)) begin
                        state_r    <= LOCKED;
                        lock_r     <= 1'b1;
                        sh_cnt_r   <= SH_W'(0);
                        sh_invld_r <= IV_W'(0);
                     end else begin
                        sh_cnt_r <= sh_inc_s;
                     end
                  end else begin
                     slip_r     <= 1'b1;
                     sh_cnt_r   <= SH_W'(0);
                     sh_invld_r <= IV_W'(0);
                  end
               end
               LOCKED: begin
                  // too many bad headers wins over a window completing on the same block
                  if (iv_inc_s == IV_W'(INVLD_MAX)) begin
                     slip_r     <= 1'b1;
                     state_r    <= HUNT;
                     lock_r     <= 1'b0;
                     sh_cnt_r   <= SH_W'(0);
                     sh_invld_r <= IV_W'(0);
                  end else if (sh_inc_s == SH_W'(LOCK_CNT)) begin
                     sh_cnt_r   <= SH_W'(0);
                     sh_invld_r <= IV_W'(0);
                  end else begin
                     sh_cnt_r   <= sh_inc_s;
                     sh_invld_r <= iv_inc_s;
                  end
               end
               default: begin
                  state_r    <= HUNT;
                  lock_r     <= 1'b0;
                  sh_cnt_r   <= SH_W'(0);
                  sh_invld_r <= IV_W'(0);
               end
            endcase
         end
      end
   end

   assign slip       = slip_r;
   assign block_lock = lock_r;

endmodule

// File: rtl/block_sync_deser.sv
// Block synchroniser: finds the 66-bit boundary in the descrambled serial stream
// and delivers aligned header + payload. Optional counters under BLOCK_SYNC_STATS_EN.
module block_sync_deser
   import block_sync_deser_pkg::*;
#(
   parameter int LOCK_CNT  = LOCK_CNT_DEF,
   parameter int INVLD_MAX = INVLD_MAX_DEF,
   parameter int BLK_W     = BLK_W_DEF
)(
   input  logic                clk,
   input  logic                rst_n,
   block_sync_deser_if.master  bus
);

   localparam int CNT_W = $clog2(BLK_W);

   // The 66-bit window is the stored history plus the bit arriving this edge,
   // so the oldest window bit never needs a flop of its own.
   logic [BLK_W-2:0]  sr_r;
   logic [BLK_W-1:0]  sr_next_s;
   logic [CNT_W-1:0]  bit_cnt_r;
   logic              boundary_s;
   logic [HDR_W-1:0]  hdr_s;
   logic              hdr_ok_s;
   logic              slip_s;
   logic              lock_s;
   logic              blk_ok_s;
   logic [DATA_W-1:0] data_r;
   logic [HDR_W-1:0]  hdr_r;
   logic              valid_r;

   assign sr_next_s  = {sr_r, bus.serial_data_in};
   assign boundary_s = (bit_cnt_r == CNT_W'(BLK_W - 1));
   assign hdr_s      = sr_next_s[BLK_W-1:BLK_W-HDR_W];
   assign hdr_ok_s   = hdr_valid(hdr_s);

   block_lock_fsm #(
      .LOCK_CNT  (LOCK_CNT),
      .INVLD_MAX (INVLD_MAX)
   ) u_lock_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .boundary   (boundary_s),
      .hdr_ok     (hdr_ok_s),
      .slip       (slip_s),
      .block_lock (lock_s),
      .blk_ok     (blk_ok_s)
   );

   // serial history and bit position; a slip freezes the position for one edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_r      <= {(BLK_W-1){1'b0}};
         bit_cnt_r <= CNT_W'(0);
      end else begin
         sr_r <= sr_next_s[BLK_W-2:0];
         if (boundary_s) begin
            bit_cnt_r <= CNT_W'(0);
         end else if (slip_s) begin
            bit_cnt_r <= bit_cnt_r;
         end else begin
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
         end
      end
   end

   // block outputs captured at each boundary, held in between
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r  <= {DATA_W{1'b0}};
         hdr_r   <= {HDR_W{1'b0}};
         valid_r <= 1'b0;
      end else begin
         valid_r <= boundary_s & blk_ok_s;
         if (boundary_s) begin
            data_r <= sr_next_s[DATA_W-1:0];
            hdr_r  <= hdr_s;
         end
      end
   end

   assign bus.block_data_out = data_r;
   assign bus.block_hdr_out  = hdr_r;
   assign bus.block_valid    = valid_r;
   assign bus.block_lock     = lock_s;

`ifdef BLOCK_SYNC_STATS_EN
   logic [15:0] hdr_err_r;
   logic [15:0] slip_cnt_r;

   // saturating diagnostics: bad headers while locked, and slips taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hdr_err_r  <= 16'd0;
         slip_cnt_r <= 16'd0;
      end else begin
         if (boundary_s && lock_s && !hdr_ok_s && (hdr_err_r != 16'hFFFF)) begin
            hdr_err_r <= hdr_err_r + 16'd1;
         end
         if (slip_s && (slip_cnt_r != 16'hFFFF)) begin
            slip_cnt_r <= slip_cnt_r + 16'd1;
         end
      end
   end

   assign bus.hdr_err_cnt = hdr_err_r;
   assign bus.slip_cnt    = slip_cnt_r;
`else
   // statistics disabled: no extra state or ports
`endif

endmodule

// File: tb/tb_block_sync_deser.sv
// Self-checking bench for block_sync_deser: block-level reference model compared every
// cycle, plus constant-expectation tables and sequences for lock, loss and reset cases.
module tb_block_sync_deser;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   block_sync_deser_if bus();

   block_sync_deser u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_vec;
   int n_err;
   int valid_seen;

   // reference model: absolute edge index, scheduled boundary, recent bits, lock bookkeeping
   int          e_idx;
   int          next_bnd;
   logic        hist[$];
   bit          m_lock;
   int          run_good;
   int          win_blk;
   int          win_bad;
   logic        m_valid;
   logic [1:0]  m_hdr;
   logic [63:0] m_data;
   int          m_err;
   int          m_slip;
   bit          slip_pend;

   typedef struct {
      logic [1:0]  hdr;
      logic [63:0] data;
      logic        exp_valid;
      logic        exp_lock;
   } vec_t;
   vec_t tbl [8];

   localparam logic [63:0] PAT = 64'h0123_4567_89AB_CDEF;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      e_idx     = 0;
      next_bnd  = 65;
      hist.delete();
      m_lock    = 1'b0;
      run_good  = 0;
      win_blk   = 0;
      win_bad   = 0;
      m_valid   = 1'b0;
      m_hdr     = 2'b00;
      m_data    = 64'd0;
      m_err     = 0;
      m_slip    = 0;
      slip_pend = 1'b0;
   endtask

   task automatic model_edge(input logic b);
      bit good;
      bit slip;
      if (slip_pend) begin
         m_slip++;
         slip_pend = 1'b0;
      end
      hist.push_back(b);
      if (hist.size() > 66) void'(hist.pop_front());
      m_valid = 1'b0;
      if (e_idx == next_bnd) begin
         m_hdr = {hist[0], hist[1]};
         for (int k = 0; k < 64; k++) m_data[63-k] = hist[2+k];
         good = (m_hdr == 2'b01) || (m_hdr == 2'b10);
         slip = 1'b0;
         if (!m_lock) begin
            if (good) begin
               run_good++;
               if (run_good == 64) begin
                  m_lock   = 1'b1;
                  run_good = 0;
                  win_blk  = 0;
                  win_bad  = 0;
               end
            end else begin
               slip     = 1'b1;
               run_good = 0;
            end
         end else begin
            win_blk++;
            if (!good) begin
               win_bad++;
               m_err++;
            end
            if (win_bad == 16) begin
               m_lock  = 1'b0;
               slip    = 1'b1;
               win_blk = 0;
               win_bad = 0;
            end else begin
               m_valid = 1'b1;
               if (win_blk == 64) begin
                  win_blk = 0;
                  win_bad = 0;
               end
            end
         end
         if (slip) slip_pend = 1'b1;
         next_bnd = e_idx + (slip ? 67 : 66);
      end
      e_idx++;
   endtask

   task automatic step(input logic b);
      bus.serial_data_in = b;
      @(posedge clk);
      #1;
      model_edge(b);
      if (bus.block_valid) valid_seen++;
      check("outs", 128'({bus.block_valid, bus.block_lock, bus.block_hdr_out, bus.block_data_out}),
            128'({m_valid, m_lock, m_hdr, m_data}));
`ifdef BLOCK_SYNC_STATS_EN
      check("stats", 128'({bus.hdr_err_cnt, bus.slip_cnt}), 128'({m_err[15:0], m_slip[15:0]}));
`endif
   endtask

   task automatic do_reset(input int ncyc);
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_async", 128'({bus.block_valid, bus.block_lock, bus.block_hdr_out, bus.block_data_out}), 128'(0));
      repeat (ncyc) begin
         bus.serial_data_in = 1'($urandom);
         @(posedge clk);
         #1;
      end
      check("reset_hold", 128'({bus.block_valid, bus.block_lock, bus.block_hdr_out, bus.block_data_out}), 128'(0));
`ifdef BLOCK_SYNC_STATS_EN
      check("reset_stats", 128'({bus.hdr_err_cnt, bus.slip_cnt}), 128'(0));
`endif
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic send_block(input logic [1:0] hdr, input logic [63:0] data);
      for (int k = 0; k < 66; k++) begin
         if (k < 2) step(hdr[1-k]);
         else       step(data[63-(k-2)]);
      end
   endtask

   // nbad bad headers at the front of an nblk-block stretch, all of them tolerated
   task automatic send_window(input int nblk, input int nbad);
      logic [1:0] h;
      for (int j = 0; j < nblk; j++) begin
         if (j < nbad) h = j[0] ? 2'b00 : 2'b11;
         else          h = j[0] ? 2'b10 : 2'b01;
         send_block(h, {$urandom, $urandom});
         check("window_ctl", 128'({bus.block_valid, bus.block_lock}), 128'(2'b11));
      end
   endtask

   task automatic acquire_aligned();
      for (int i = 0; i < 64; i++) begin
         send_block(2'b01, PAT);
         check("lock_acq", 128'({bus.block_valid, bus.block_lock}), 128'({1'b0, (i == 63)}));
      end
   endtask

   initial begin
      bit got;
      logic [1:0]  rh;
      logic [63:0] rd;
      n_vec = 0;
      n_err = 0;
      bus.serial_data_in = 1'b0;
      model_reset();

      tbl[0] = '{2'b01, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b1};
      tbl[1] = '{2'b10, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b1};
      tbl[2] = '{2'b11, 64'hDEAD_BEEF_0000_0000, 1'b1, 1'b1};
      tbl[3] = '{2'b01, 64'h0000_0000_0000_0000, 1'b1, 1'b1};
      tbl[4] = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
      tbl[5] = '{2'b10, 64'hAAAA_5555_AAAA_5555, 1'b1, 1'b1};
      tbl[6] = '{2'b01, 64'h8000_0000_0000_0001, 1'b1, 1'b1};
      tbl[7] = '{2'b10, 64'h0000_0001_0000_0000, 1'b1, 1'b1};

      // reset with random input, then random stream must never lock or strobe
      do_reset(10);
      valid_seen = 0;
      for (int i = 0; i < 66 * 64; i++) step(1'($urandom));
      check("no_valid_random", 128'(valid_seen), 128'(0));

      // aligned acquisition, then table of locked blocks (first window starts here)
      do_reset(3);
      acquire_aligned();
      for (int i = 0; i < 8; i++) begin
         send_block(tbl[i].hdr, tbl[i].data);
         check("tbl_ctl", 128'({bus.block_valid, bus.block_lock}), 128'({tbl[i].exp_valid, tbl[i].exp_lock}));
         check("tbl_blk", 128'({bus.block_hdr_out, bus.block_data_out}), 128'({tbl[i].hdr, tbl[i].data}));
      end

      // tolerated errors: 15 bad per window over three windows (2 already in the table)
      send_window(56, 13);
      send_window(64, 15);
      send_window(64, 15);
`ifdef BLOCK_SYNC_STATS_EN
      check("hdr_err_45", 128'(bus.hdr_err_cnt), 128'(16'd45));
`endif

      // loss of lock: 16 headers of 11 within one window
      for (int j = 0; j < 32; j++) begin
         send_block(j[0] ? 2'b11 : 2'b01, {$urandom, $urandom});
         if (j == 31) check("lock_lost", 128'({bus.block_valid, bus.block_lock}), 128'(2'b00));
         else         check("pre_loss",  128'({bus.block_valid, bus.block_lock}), 128'(2'b11));
      end
      for (int i = 0; i < 70; i++) step(1'($urandom));

      // relock, then reset 30 bits into a block
      do_reset(3);
      acquire_aligned();
      send_block(2'b01, PAT);
      for (int k = 0; k < 30; k++) begin
         if (k < 2) step(k == 1);
         else       step(PAT[63-(k-2)]);
      end
      check("locked_before_rst", 128'({bus.block_lock, bus.block_data_out}), 128'({1'b1, PAT}));
      do_reset(5);

      // misaligned by 5 bits: hunt must slip into place and reacquire from scratch
      for (int i = 0; i < 5; i++) step(1'($urandom));
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         send_block(($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, {$urandom, $urandom});
         if (bus.block_lock) got = 1'b1;
      end
      check("misalign_lock", 128'(got), 128'(1));
      for (int i = 0; i < 4; i++) begin
         rh = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
         rd = {$urandom, $urandom};
         send_block(rh, rd);
         check("misalign_blk", 128'({bus.block_valid, bus.block_hdr_out, bus.block_data_out}), 128'({1'b1, rh, rd}));
      end
`ifdef BLOCK_SYNC_STATS_EN
      check("slip_cnt_min", 128'(bus.slip_cnt >= 16'd1), 128'(1));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
